// File: rtl/compare_streak_monitor.sv
// compare_streak_monitor: registered event counters, gt-streak alarm and one-hot error flag for a magnitude comparator
//
// Ports:
//   clk, rst_n               rising-edge clock, asynchronous active-low reset
//   in_valid                 comparator result valid this cycle
//   a_gt_b, a_eq_b, a_lt_b   comparator result, expected one-hot
//   clear                    synchronous clear of counters, streak, FSM and alarm
//   gt_cnt, eq_cnt, lt_cnt   saturating counts of legal valid samples per outcome
//   streak                   saturating length of the current run of legal gt samples
//   alarm                    streak reached THRESH
//   alarm_rise               one-cycle pulse when alarm goes 0->1
//   err                      one-cycle pulse for a valid sample that is not one-hot
//
// Build option: define STICKY_ALARM_EN to latch alarm until clear/reset,
// with alarm_rise only on the first set after each clear/reset.
module compare_streak_monitor #(
   parameter int CNT_W  = 8,
   parameter int THRESH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   input  logic             a_gt_b,
   input  logic             a_eq_b,
   input  logic             a_lt_b,
   input  logic             clear,
   output logic [CNT_W-1:0] gt_cnt,
   output logic [CNT_W-1:0] eq_cnt,
   output logic [CNT_W-1:0] lt_cnt,
   output logic [CNT_W-1:0] streak,
   output logic             alarm,
   output logic             alarm_rise,
   output logic             err
);
   typedef enum logic [1:0] {IDLE, ARMING, ALARM} state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] gt_cnt_q, gt_cnt_d, eq_cnt_q, eq_cnt_d, lt_cnt_q, lt_cnt_d;
   logic [CNT_W-1:0] streak_q, streak_d;
   logic             alarm_q, alarm_d, alarm_rise_q, alarm_rise_d, err_q, err_d;
   logic [2:0]       code;
   logic             legal;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] x);
      return (x == '1) ? x : x + 1'b1;
   endfunction

   assign code  = {a_gt_b, a_eq_b, a_lt_b};
   assign legal = (code == 3'b100) || (code == 3'b010) || (code == 3'b001);

   always_comb begin
      gt_cnt_d = gt_cnt_q;
      eq_cnt_d = eq_cnt_q;
      lt_cnt_d = lt_cnt_q;
      streak_d = streak_q;
      state_d  = state_q;
      err_d    = 1'b0;
      if (clear) begin
         gt_cnt_d = '0;
         eq_cnt_d = '0;
         lt_cnt_d = '0;
         streak_d = '0;
         state_d  = IDLE;
      end else if (in_valid && legal) begin
         gt_cnt_d = a_gt_b ? sat_inc(gt_cnt_q) : gt_cnt_q;
         eq_cnt_d = a_eq_b ? sat_inc(eq_cnt_q) : eq_cnt_q;
         lt_cnt_d = a_lt_b ? sat_inc(lt_cnt_q) : lt_cnt_q;
         streak_d = a_gt_b ? sat_inc(streak_q) : '0;
         // next state is judged on the post-update streak
         state_d  = !a_gt_b ? IDLE :
                    (state_q == ALARM || streak_d >= CNT_W'(THRESH)) ? ALARM : ARMING;
      end else if (in_valid) begin
         err_d    = 1'b1;
         streak_d = '0;
         state_d  = IDLE;
      end
`ifdef STICKY_ALARM_EN
      alarm_d      = !clear && (alarm_q || state_d == ALARM);
      alarm_rise_d = alarm_d && !alarm_q;
`else
      alarm_d      = (state_d == ALARM);
      alarm_rise_d = alarm_d && (state_q != ALARM);
`endif
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         gt_cnt_q     <= '0;
         eq_cnt_q     <= '0;
         lt_cnt_q     <= '0;
         streak_q     <= '0;
         alarm_q      <= 1'b0;
         alarm_rise_q <= 1'b0;
         err_q        <= 1'b0;
      end else begin
         state_q      <= state_d;
         gt_cnt_q     <= gt_cnt_d;
         eq_cnt_q     <= eq_cnt_d;
         lt_cnt_q     <= lt_cnt_d;
         streak_q     <= streak_d;
         alarm_q      <= alarm_d;
         alarm_rise_q <= alarm_rise_d;
         err_q        <= err_d;
      end
   end

   assign gt_cnt     = gt_cnt_q;
   assign eq_cnt     = eq_cnt_q;
   assign lt_cnt     = lt_cnt_q;
   assign streak     = streak_q;
   assign alarm      = alarm_q;
   assign alarm_rise = alarm_rise_q;
   assign err        = err_q;
endmodule

// File: tb/tb_compare_streak_monitor.sv
// tb_compare_streak_monitor: random and directed checks of two monitor instances against a run-length model
module tb_compare_streak_monitor;
   logic clk = 1'b0, rst_n = 1'b0;
   logic in_valid = 1'b0, a_gt_b = 1'b0, a_eq_b = 1'b0, a_lt_b = 1'b0, clear = 1'b0;
   logic [7:0] g0, e0, l0, s0;
   logic [1:0] g1, e1, l1, s1;
   logic al0, ar0, er0, al1, ar1, er1;
   int compared = 0, mismatched = 0;

   always #5 clk = ~clk;

   compare_streak_monitor #(.CNT_W(8), .THRESH(4)) u0 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .a_gt_b(a_gt_b), .a_eq_b(a_eq_b),
      .a_lt_b(a_lt_b), .clear(clear), .gt_cnt(g0), .eq_cnt(e0), .lt_cnt(l0), .streak(s0),
      .alarm(al0), .alarm_rise(ar0), .err(er0));

   compare_streak_monitor #(.CNT_W(2), .THRESH(2)) u1 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .a_gt_b(a_gt_b), .a_eq_b(a_eq_b),
      .a_lt_b(a_lt_b), .clear(clear), .gt_cnt(g1), .eq_cnt(e1), .lt_cnt(l1), .streak(s1),
      .alarm(al1), .alarm_rise(ar1), .err(er1));

   // model: per instance, counts and the unsaturated length of the current gt run;
   // the FSM is in ALARM exactly when that run has reached THRESH
   int mx[2] = '{255, 3};
   int th[2] = '{4, 2};
   int cnt[2][3];
   int run[2];
   bit fsm[2], alm[2], rise[2], errm[2];
`ifdef STICKY_ALARM_EN
   localparam bit STICKY = 1'b1;
`else
   localparam bit STICKY = 1'b0;
`endif

   function automatic int min2(int a, int b);
      return a < b ? a : b;
   endfunction

   task automatic model_reset();
      for (int k = 0; k < 2; k++) begin
         for (int j = 0; j < 3; j++) cnt[k][j] = 0;
         run[k] = 0; fsm[k] = 0; alm[k] = 0; rise[k] = 0; errm[k] = 0;
      end
   endtask

   task automatic model_edge();
      int ones;
      bit nf;
      ones = int'(a_gt_b) + int'(a_eq_b) + int'(a_lt_b);
      for (int k = 0; k < 2; k++) begin
         rise[k] = 0; errm[k] = 0;
         if (clear) begin
            for (int j = 0; j < 3; j++) cnt[k][j] = 0;
            run[k] = 0; fsm[k] = 0; alm[k] = 0;
         end else if (in_valid && ones == 1) begin
            if (a_gt_b) cnt[k][0] = min2(cnt[k][0] + 1, mx[k]);
            if (a_eq_b) cnt[k][1] = min2(cnt[k][1] + 1, mx[k]);
            if (a_lt_b) cnt[k][2] = min2(cnt[k][2] + 1, mx[k]);
            run[k] = a_gt_b ? run[k] + 1 : 0;
            nf = run[k] >= th[k];
            rise[k] = STICKY ? (nf && !alm[k]) : (nf && !fsm[k]);
            alm[k]  = STICKY ? (alm[k] || nf) : nf;
            fsm[k]  = nf;
         end else if (in_valid) begin
            errm[k] = 1; run[k] = 0; fsm[k] = 0;
            if (!STICKY) alm[k] = 0;
         end
      end
   endtask

   task automatic chk(input string n, input int act, input int exp);
      compared++;
      if (act != exp) begin
         mismatched++;
         $display("FAIL %s at %0t: got %0d expected %0d", n, $time, act, exp);
      end
   endtask

   always @(negedge clk) begin
      chk("gt_cnt0", int'(g0), cnt[0][0]);
      chk("eq_cnt0", int'(e0), cnt[0][1]);
      chk("lt_cnt0", int'(l0), cnt[0][2]);
      chk("streak0", int'(s0), min2(run[0], mx[0]));
      chk("alarm0", int'(al0), int'(alm[0]));
      chk("rise0", int'(ar0), int'(rise[0]));
      chk("err0", int'(er0), int'(errm[0]));
      chk("gt_cnt1", int'(g1), cnt[1][0]);
      chk("eq_cnt1", int'(e1), cnt[1][1]);
      chk("lt_cnt1", int'(l1), cnt[1][2]);
      chk("streak1", int'(s1), min2(run[1], mx[1]));
      chk("alarm1", int'(al1), int'(alm[1]));
      chk("rise1", int'(ar1), int'(rise[1]));
      chk("err1", int'(er1), int'(errm[1]));
   end

   task automatic step(input bit v, input bit g, input bit e, input bit l, input bit c);
      in_valid = v; a_gt_b = g; a_eq_b = e; a_lt_b = l; clear = c;
      @(posedge clk);
      model_edge();
      #1;
   endtask

   task automatic async_reset();
      #2 rst_n = 1'b0;
      #1;
      chk("rst_async_cnt", int'(g0) + int'(e0) + int'(l0) + int'(s0), 0);
      chk("rst_async_flags", int'({al0, ar0, er0, al1, ar1, er1}), 0);
      model_reset();
      @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   initial begin
      int gc, ec, lc, r;
      model_reset();
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      chk("reset_streak", int'(s0), 0);
      // streak to threshold
      for (int i = 1; i <= 4; i++) begin
         step(1, 1, 0, 0, 0);
         chk("t2_streak", int'(s0), i);
      end
      chk("t2_alarm", int'(al0), 1);
      chk("t2_rise", int'(ar0), 1);
      step(0, 0, 0, 0, 0);
      chk("t2_rise_once", int'(ar0), 0);
      step(1, 0, 0, 1, 0);
      chk("t2_lt_streak", int'(s0), 0);
      chk("t2_lt_alarm", int'(al0), int'(STICKY));
      // gaps do not break a run
      step(1, 0, 0, 0, 1);
      step(1, 1, 0, 0, 0); step(1, 1, 0, 0, 0);
      repeat (3) step(0, 0, 0, 0, 0);
      step(1, 1, 0, 0, 0);
      chk("t3_no_alarm_yet", int'(al0), 0);
      step(1, 1, 0, 0, 0);
      chk("t3_alarm", int'(al0), 1);
      step(1, 0, 0, 0, 1);
      step(1, 1, 0, 0, 0); step(1, 0, 1, 0, 0);
      repeat (3) step(1, 1, 0, 0, 0);
      chk("t3_streak3", int'(s0), 3);
      chk("t3_no_alarm", int'(al0), 0);
      // illegal codes
      gc = int'(g0); ec = int'(e0); lc = int'(l0);
      step(1, 1, 1, 0, 0);
      chk("t4_err", int'(er0), 1);
      chk("t4_cnts", int'(g0) * 65536 + int'(e0) * 256 + int'(l0), gc * 65536 + ec * 256 + lc);
      chk("t4_streak", int'(s0), 0);
      step(1, 0, 0, 0, 0);
      chk("t4_err000", int'(er0), 1);
      chk("t4_gt000", int'(g0), gc);
      step(0, 0, 0, 0, 0);
      chk("t4_err_pulse", int'(er0), 0);
      // saturation on the narrow instance
      step(1, 0, 0, 0, 1);
      repeat (5) step(1, 0, 1, 0, 0);
      chk("t5_eq_sat", int'(e1), 3);
      repeat (5) step(1, 1, 0, 0, 0);
      chk("t5_gt_sat", int'(g1), 3);
      chk("t5_streak_sat", int'(s1), 3);
      // clear wins over a same-cycle sample
      step(1, 1, 0, 0, 1);
      chk("t6_gt", int'(g0), 0);
      chk("t6_alarm", int'(al0), 0);
      chk("t6_rise", int'(ar0), 0);
      // async reset mid-stream
      repeat (3) step(1, 1, 0, 0, 0);
      async_reset();
      chk("t1_after", int'(g0) + int'(s0), 0);
      // random traffic
      for (int i = 0; i < 4000; i++) begin
         r = int'($urandom_range(0, 99));
         if (i % 1500 == 1499) async_reset();
         else if (r < 2) step(1, 1, 0, 0, 1);
         else if (r < 15) step(0, $urandom_range(0, 1) == 1, 0, 0, 0);
         else if (r < 20) step(1, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
                               $urandom_range(0, 1) == 1, 0);
         else if (r < 70) step(1, 1, 0, 0, 0);
         else if (r < 85) step(1, 0, 1, 0, 0);
         else step(1, 0, 0, 1, 0);
      end
      @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule
